// File: rtl/mul_if.sv
// Handshake bundle between the execute stage and the multiply unit: operation request
// channel plus tagged result channel, each with its own valid/ready pair.
interface mul_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   acc;
    logic [TAG_W-1:0]     tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     res_lo;
    logic [WIDTH-1:0]     res_hi;
    logic [TAG_W-1:0]     out_tag;
    logic                 n_flag;
    logic                 z_flag;

    modport master (
        output in_valid, op, a, b, acc, tag, out_ready,
        input  in_ready, out_valid, res_lo, res_hi, out_tag, n_flag, z_flag
    );

    modport slave (
        input  in_valid, op, a, b, acc, tag, out_ready,
        output in_ready, out_valid, res_lo, res_hi, out_tag, n_flag, z_flag
    );
endinterface

// File: rtl/mul_unit.sv
// Pipelined MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit. The product is formed on entry, the
// accumulate and flag generation happen on the last register stage; all stages stall together.
module mul_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    mul_if.slave   bus
);

    localparam int DW = 2 * WIDTH;

    typedef struct packed {
        logic              valid;
        logic              is_long;
        logic [TAG_W-1:0]  tag;
        logic [DW-1:0]     prod;
        logic [DW-1:0]     addend;
    } mid_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [WIDTH-1:0]  hi;
        logic [WIDTH-1:0]  lo;
        logic              n;
        logic              z;
    } out_t;

    // Final add and flag derivation; short ops keep only the low half of the sum.
    function automatic out_t finish(input mid_t m);
        logic [DW-1:0] sum;
        out_t          r;
        sum     = m.prod + m.addend;
        r.valid = m.valid;
        r.tag   = m.tag;
        r.hi    = m.is_long ? sum[DW-1:WIDTH] : '0;
        r.lo    = sum[WIDTH-1:0];
        r.n     = m.is_long ? sum[DW-1] : sum[WIDTH-1];
        r.z     = (r.lo == '0) && (r.hi == '0);
        return r;
    endfunction

    logic          stall;
    logic          is_long;
    logic          is_signed;
    logic          is_acc;
    logic [DW-1:0] ext_a;
    logic [DW-1:0] ext_b;
    mid_t          front;
    out_t          out_q;

    assign stall = out_q.valid & ~bus.out_ready;

    // NOTE: every variable is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        is_long   = bus.op[2];
        is_signed = bus.op[2] & bus.op[1];
        is_acc    = is_long ? bus.op[0] : (bus.op[1:0] == 2'b01);
        ext_a     = is_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
        ext_b     = is_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};

        front.valid   = bus.in_valid & ~stall;
        front.is_long = is_long;
        front.tag     = bus.tag;
        front.prod    = ext_a * ext_b;
        if (!is_acc)
            front.addend = '0;
        else if (is_long)
            front.addend = bus.acc;
        else
            front.addend = {{WIDTH{1'b0}}, bus.acc[WIDTH-1:0]};
    end

    generate
        if (STAGES == 1) begin : g_single
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    out_q <= '0;
                else if (!stall)
                    out_q <= finish(front);
            end
        end else begin : g_multi
            mid_t mid_q [STAGES-1];

            // NOTE: the whole pipe array is reset, not just the valid bits, so result fields read 0 in reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES - 1; i++)
                        mid_q[i] <= '0;
                    out_q <= '0;
                end else if (!stall) begin
                    mid_q[0] <= front;
                    for (int i = 1; i < STAGES - 1; i++)
                        mid_q[i] <= mid_q[i-1];
                    out_q <= finish(mid_q[STAGES-2]);
                end
            end
        end
    endgenerate

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_q.valid;
    assign bus.out_tag   = out_q.tag;
    assign bus.res_hi    = out_q.hi;
    assign bus.res_lo    = out_q.lo;
    assign bus.n_flag    = out_q.n;
    assign bus.z_flag    = out_q.z;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases, reset flush, stall stream and a
// randomized run scored in order against an arithmetic reference model.
module tb_mul_unit;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;
    localparam int DW     = 2 * WIDTH;
    localparam int N_RAND = 3000;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    res;
        logic             n;
        logic             z;
        bit               lat_chk;
        int               acc_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    mul_unit #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t              sb_q[$];
    exp_t              nxt_exp;
    int                total = 0;
    int                bad   = 0;
    int                cyc   = 0;
    logic              prev_stall = 1'b0;
    logic [DW-1:0]     snap_res;
    logic [TAG_W+2:0]  snap_ctl;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definition of each opcode.
    function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic [DW-1:0] acc,
                                   input logic [TAG_W-1:0] tag);
        exp_t                 e;
        logic [DW-1:0]        full;
        logic [WIDTH-1:0]     short_r;
        logic signed [DW-1:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'b100:  full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            3'b101:  full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b} + acc;
            3'b110:  full = sa * sb;
            3'b111:  full = sa * sb + acc;
            3'b001: begin
                short_r = a * b + acc[WIDTH-1:0];
                full    = {{WIDTH{1'b0}}, short_r};
            end
            default: begin
                short_r = a * b;
                full    = {{WIDTH{1'b0}}, short_r};
            end
        endcase
        e.tag     = tag;
        e.res     = full;
        e.n       = op[2] ? full[DW-1] : full[WIDTH-1];
        e.z       = (full == '0);
        e.lat_chk = 1'b0;
        e.acc_cyc = 0;
        return e;
    endfunction

    function automatic exp_t mk_exp(input logic [TAG_W-1:0] tag, input logic [DW-1:0] res,
                                    input logic n, input logic z);
        exp_t e;
        e.tag     = tag;
        e.res     = res;
        e.n       = n;
        e.z       = z;
        e.lat_chk = 1'b1;
        e.acc_cyc = 0;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(5))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'(1) << (WIDTH - 1);
            default: return WIDTH'($urandom());
        endcase
    endfunction

    // One clock: inputs already driven after the falling edge; sample, score, advance.
    task automatic cycle(input logic rdy, output bit took);
        logic accepted, consumed;
        exp_t e;
        bus.out_ready = rdy;
        #1;
        accepted = bus.in_valid & bus.in_ready;
        consumed = bus.out_valid & bus.out_ready;
        check("in_ready", DW'(bus.in_ready), DW'(!(bus.out_valid && !bus.out_ready)));
        if (prev_stall) begin
            check("hold_res", {bus.res_hi, bus.res_lo}, snap_res);
            check("hold_ctl", DW'({bus.out_valid, bus.out_tag, bus.n_flag, bus.z_flag}), DW'(snap_ctl));
        end
        prev_stall = bus.out_valid & ~bus.out_ready;
        snap_res   = {bus.res_hi, bus.res_lo};
        snap_ctl   = {bus.out_valid, bus.out_tag, bus.n_flag, bus.z_flag};
        if (consumed) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", DW'(bus.out_valid), '0);
            end else begin
                e = sb_q.pop_front();
                check("out_tag", DW'(bus.out_tag), DW'(e.tag));
                check("result", {bus.res_hi, bus.res_lo}, e.res);
                check("n_flag", DW'(bus.n_flag), DW'(e.n));
                check("z_flag", DW'(bus.z_flag), DW'(e.z));
                if (e.lat_chk)
                    check("latency", DW'(cyc - e.acc_cyc), DW'(STAGES));
            end
        end
        if (accepted) begin
            e         = nxt_exp;
            e.acc_cyc = cyc;
            sb_q.push_back(e);
        end
        took = accepted;
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [DW-1:0] acc, input logic [TAG_W-1:0] tag, input exp_t e);
        bit took = 1'b0;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.acc      = acc;
        bus.tag      = tag;
        nxt_exp      = e;
        for (int k = 0; k < 50 && !took; k++)
            cycle(1'b1, took);
        check("accept", DW'(took), DW'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit t;
        for (int k = 0; k < 200 && sb_q.size() > 0; k++)
            cycle(1'b1, t);
        check("drain_empty", DW'(sb_q.size()), '0);
    endtask

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] ra, rb;
    logic [DW-1:0]    racc;
    logic [2:0]       rop;
    logic [WIDTH-1:0] s_a [4];
    logic [WIDTH-1:0] s_b [4];

    initial begin
        bit t;
        int idx, hold, sent;
        bit pending;

        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.acc       = '0;
        bus.tag       = '0;
        bus.out_ready = 1'b0;
        ones          = '1;
        half          = WIDTH'(1) << (WIDTH / 2);

        // Reset state
        #12;
        check("rst_valid", DW'(bus.out_valid), '0);
        check("rst_res", {bus.res_hi, bus.res_lo}, '0);
        check("rst_tag_flags", DW'({bus.out_tag, bus.n_flag, bus.z_flag}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", DW'(bus.in_ready), DW'(1));
        @(negedge clk);

        // Directed corner cases, back to back with out_ready high
        send(3'b100, ones, ones, '0, 4'd1, mk_exp(4'd1, {ones - WIDTH'(1), WIDTH'(1)}, 1'b1, 1'b0));
        send(3'b110, ones, WIDTH'(2), '0, 4'd2, mk_exp(4'd2, {ones, ones - WIDTH'(1)}, 1'b1, 1'b0));
        send(3'b111, ones, WIDTH'(2), DW'(2), 4'd3, mk_exp(4'd3, '0, 1'b0, 1'b1));
        send(3'b001, half, half, {WIDTH'(32'hDEADBEEF), WIDTH'(5)}, 4'd4,
             mk_exp(4'd4, DW'(5), 1'b0, 1'b0));
        send(3'b010, WIDTH'(3), WIDTH'(5), '1, 4'd5, mk_exp(4'd5, DW'(15), 1'b0, 1'b0));
        send(3'b101, ones, ones, '1, 4'd6, mk_exp(4'd6, {ones - WIDTH'(1), WIDTH'(0)}, 1'b1, 1'b0));
        send(3'b000, ones, WIDTH'(1), '0, 4'd7, mk_exp(4'd7, {WIDTH'(0), ones}, 1'b1, 1'b0));
        drain();

        // Reset with two operations in flight
        send(3'b100, WIDTH'(7), WIDTH'(9), '0, 4'd8, model(3'b100, WIDTH'(7), WIDTH'(9), '0, 4'd8));
        send(3'b110, WIDTH'(11), WIDTH'(13), '0, 4'd9, model(3'b110, WIDTH'(11), WIDTH'(13), '0, 4'd9));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", DW'(bus.out_valid), '0);
        check("rst_mid_res", {bus.res_hi, bus.res_lo}, '0);
        sb_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * STAGES; k++)
            cycle(1'b1, t);

        // Stream of four ops with a three-cycle stall after the first result
        for (int i = 0; i < 4; i++) begin
            s_a[i] = pick();
            s_b[i] = pick();
        end
        idx  = 0;
        hold = 3;
        for (int k = 0; k < 60 && (idx < 4 || sb_q.size() > 0); k++) begin
            if (idx < 4) begin
                rop          = {1'b1, 2'(idx)};
                bus.in_valid = 1'b1;
                bus.op       = rop;
                bus.a        = s_a[idx];
                bus.b        = s_b[idx];
                bus.acc      = DW'(idx * 3);
                bus.tag      = TAG_W'(idx + 1);
                nxt_exp      = model(rop, s_a[idx], s_b[idx], DW'(idx * 3), TAG_W'(idx + 1));
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid && hold > 0) begin
                hold--;
                cycle(1'b0, t);
            end else begin
                cycle(1'b1, t);
            end
            if (t) idx++;
        end
        bus.in_valid = 1'b0;
        check("stream_ops", DW'(idx), DW'(4));
        check("stream_stalls", DW'(hold), '0);
        check("stream_drain", DW'(sb_q.size()), '0);

        // Randomized traffic with random backpressure
        sent    = 0;
        pending = 1'b0;
        for (int k = 0; k < 40000 && (sent < N_RAND || sb_q.size() > 0); k++) begin
            if (!pending && sent < N_RAND && $urandom_range(3) != 0) begin
                rop          = 3'($urandom());
                ra           = pick();
                rb           = pick();
                racc         = ($urandom_range(7) == 0) ? '1 : DW'({$urandom(), $urandom()});
                bus.in_valid = 1'b1;
                bus.op       = rop;
                bus.a        = ra;
                bus.b        = rb;
                bus.acc      = racc;
                bus.tag      = TAG_W'($urandom());
                nxt_exp      = model(rop, ra, rb, racc, bus.tag);
                pending      = 1'b1;
            end else if (!pending) begin
                bus.in_valid = 1'b0;
            end
            cycle($urandom_range(2) != 0, t);
            if (t) begin
                pending = 1'b0;
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        check("random_sent", DW'(sent), DW'(N_RAND));
        check("random_drain", DW'(sb_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
